// File: rtl/alu_ops_pkg.sv
// Shared opcodes, flag positions and FSM states
// for the ALU execute/writeback stage.
package alu_ops_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_LSR = 5'b00010;
    localparam logic [4:0] OP_LSL = 5'b00011;
    localparam logic [4:0] OP_AND = 5'b00100;
    localparam logic [4:0] OP_OR  = 5'b00101;
    localparam logic [4:0] OP_XOR = 5'b00110;
    localparam logic [4:0] OP_CMP = 5'b01000;
    localparam logic [4:0] OP_LDA = 5'b11110;
    localparam logic [4:0] OP_NOP = 5'b11111;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } state_t;

    // Codes whose ALU result is written back to the accumulator.
    function automatic logic is_alu_op(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_LSR, OP_LSL,
                          OP_AND, OP_OR, OP_XOR};
    endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Upstream operation and downstream result handshakes
// of the ALU execute/writeback stage.
interface alu_exec_stage_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   in_op;
    logic [W-1:0] in_operand;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [3:0]   out_flags;

    modport master (
        output in_valid,
        input  in_ready,
        output in_op,
        output in_operand,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_flags
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_op,
        input  in_operand,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_flags
    );
endinterface

// File: rtl/alu.sv
// Combinational W-bit ALU: add/sub, shifts, logic ops.
// C is carry (add), borrow (sub) or last bit shifted out.
module alu
    import alu_ops_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [4:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);

    logic [W:0]   wide;
    logic [W-1:0] res;
    logic         c;
    logic         v;

    always_comb begin
        wide = '0;
        res  = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (op)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                res  = wide[W-1:0];
                c    = wide[W];
                v    = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
            end
            OP_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                res  = wide[W-1:0];
                c    = wide[W];
                v    = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
            end
            OP_LSL: begin
                wide = {1'b0, a} << b;
                res  = wide[W-1:0];
                c    = wide[W];
            end
            OP_LSR: begin
                wide = {a, 1'b0} >> b;
                res  = wide[W:1];
                c    = wide[0];
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            default: res = '0;
        endcase
    end

    always_comb begin
        result         = res;
        flags          = '0;
        flags[FLAG_N]  = res[W-1];
        flags[FLAG_Z]  = (res == '0);
        flags[FLAG_C]  = c;
        flags[FLAG_V]  = v;
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute/writeback stage: accumulator-based ALU with
// valid/ready operation intake and result delivery.
module alu_exec_stage
    import alu_ops_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    alu_exec_stage_if.slave bus,
    output logic [W-1:0] acc,
    output logic         busy
);

    state_t       state;
    state_t       state_nxt;
    logic [4:0]   op_r;
    logic [W-1:0] opnd_r;
    logic [3:0]   flags;
    logic         out_valid_r;
    logic [W-1:0] out_data_r;
    logic [3:0]   out_flags_r;

    logic [4:0]   alu_op;
    logic [W-1:0] alu_res;
    logic [3:0]   alu_flags;
    logic [W-1:0] acc_nxt;
    logic [3:0]   flags_nxt;

    assign alu_op = (op_r == OP_CMP) ? OP_SUB : op_r;

    alu #(.W(W)) u_alu (
        .op     (alu_op),
        .a      (acc),
        .b      (opnd_r),
        .result (alu_res),
        .flags  (alu_flags)
    );

    always_comb begin
        acc_nxt   = acc;
        flags_nxt = flags;
        unique case (1'b1)
            is_alu_op(op_r): begin
                acc_nxt   = alu_res;
                flags_nxt = alu_flags;
            end
            (op_r == OP_CMP): flags_nxt = alu_flags;
            (op_r == OP_LDA): acc_nxt   = opnd_r;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.in_valid)  state_nxt = EXEC;
            EXEC: state_nxt = WB;
            WB:   if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            flags       <= '0;
            op_r        <= '0;
            opnd_r      <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_flags_r <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_r   <= bus.in_op;
                        opnd_r <= bus.in_operand;
                    end
                end
                EXEC: begin
                    acc         <= acc_nxt;
                    flags       <= flags_nxt;
                    out_data_r  <= acc_nxt;
                    out_flags_r <= flags_nxt;
                    out_valid_r <= 1'b1;
                end
                WB: begin
                    if (bus.out_ready) out_valid_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_flags = out_flags_r;
    assign busy          = (state != IDLE);

endmodule
